// File: rtl/ahblite_dac_pkg.sv
// ============================================================================
// Module   : ahblite_dac_pkg
// Brief    : Register offsets and bit positions for the AHB-Lite DAC slave.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ahblite_dac_pkg;

    // Word offsets, as seen on HADDR[3:2]
    localparam logic [1:0] c_reg_data   = 2'd0;
    localparam logic [1:0] c_reg_div    = 2'd1;
    localparam logic [1:0] c_reg_status = 2'd2;
    localparam logic [1:0] c_reg_ctrl   = 2'd3;

    localparam int c_stat_empty_bit    = 0;
    localparam int c_stat_full_bit     = 1;
    localparam int c_stat_underrun_bit = 2;
    localparam int c_stat_level_lsb    = 8;

    localparam int c_ctrl_enable_bit   = 0;
    localparam int c_ctrl_clr_urun_bit = 1;

endpackage

`default_nettype wire

// File: rtl/dac_sample_fifo.sv
// ============================================================================
// Module   : dac_sample_fifo
// Brief    : Synchronous sample FIFO with fill level; flags derive from state.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dac_sample_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic [LVL_W-1:0]      level
);

    localparam int c_aw = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]       r_wr_ptr;
    logic [c_aw-1:0]       r_rd_ptr;
    logic [LVL_W-1:0]      r_level;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign full      = (r_level == LVL_W'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    always_ff @(posedge HCLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ahblite_dac.sv
// ============================================================================
// Module   : ahblite_dac
// Brief    : AHB-Lite slave streaming buffered samples to a parallel DAC.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ahblite_dac
    import ahblite_dac_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_RESET  = 99
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [3:0]            HPROT,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [31:0]           HRDATA,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] dac_data,
    output logic                  dac_valid
);

    localparam int c_lvl_w = $clog2(FIFO_DEPTH) + 1;

    logic                  r_dp_valid;
    logic                  r_dp_write;
    logic [1:0]            r_dp_addr;

    logic [15:0]           r_div;
    logic [15:0]           r_count;
    logic                  r_enable;
    logic                  r_underrun;
    logic [DATA_WIDTH-1:0] r_dac_data;
    logic                  r_dac_valid;

    logic                  w_accept;
    logic                  w_stall;
    logic                  w_wr;
    logic                  w_push;
    logic                  w_div_wr;
    logic                  w_ctrl_wr;
    logic                  w_en_nxt;
    logic                  w_tick;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_fifo_dout;
    logic                  w_full;
    logic                  w_empty;
    logic [c_lvl_w-1:0]    w_level;
    logic                  w_unused_ok;

    assign w_unused_ok = ^{HSIZE, HPROT, HADDR[31:4], HADDR[1:0], HWDATA[31:16]};

    // ------------------------------------------------------------------
    // Bus pipeline
    // ------------------------------------------------------------------
    assign w_accept = HSEL & HREADY & HTRANS[1];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_addr  <= 2'd0;
        end else if (HREADY) begin
            r_dp_valid <= w_accept;
            r_dp_write <= HWRITE;
            r_dp_addr  <= HADDR[3:2];
        end
    end

    // Stall only on the registered full flag, so a pop frees the bus one cycle later
    assign w_stall   = r_dp_valid & r_dp_write & (r_dp_addr == c_reg_data) & w_full;
    assign HREADYOUT = ~w_stall;
    assign HRESP     = 1'b0;

    assign w_wr      = r_dp_valid & r_dp_write & ~w_stall;
    assign w_push    = w_wr & (r_dp_addr == c_reg_data);
    assign w_div_wr  = w_wr & (r_dp_addr == c_reg_div);
    assign w_ctrl_wr = w_wr & (r_dp_addr == c_reg_ctrl);

    always_comb begin
        HRDATA = 32'd0;
        if (r_dp_valid && !r_dp_write) begin
            case (r_dp_addr)
                c_reg_div: begin
                    HRDATA[15:0] = r_div;
                end
                c_reg_status: begin
                    HRDATA[c_stat_level_lsb +: 8]  = 8'(w_level);
                    HRDATA[c_stat_underrun_bit]    = r_underrun;
                    HRDATA[c_stat_full_bit]        = w_full;
                    HRDATA[c_stat_empty_bit]       = w_empty;
                end
                c_reg_ctrl: begin
                    HRDATA[c_ctrl_enable_bit] = r_enable;
                end
                default: begin
                    HRDATA = 32'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers and sample timer
    // ------------------------------------------------------------------
    // The enable-write cycle already counts, so the first tick lands DIV cycles later
    assign w_en_nxt = w_ctrl_wr ? HWDATA[c_ctrl_enable_bit] : r_enable;
    assign w_tick   = w_en_nxt & (r_count == r_div);
    assign w_pop    = w_tick & ~w_empty;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_div       <= 16'(DIV_RESET);
            r_count     <= 16'd0;
            r_enable    <= 1'b0;
            r_underrun  <= 1'b0;
            r_dac_data  <= '0;
            r_dac_valid <= 1'b0;
        end else begin
            if (w_div_wr) begin
                r_div <= HWDATA[15:0];
            end
            if (w_ctrl_wr) begin
                r_enable <= HWDATA[c_ctrl_enable_bit];
            end

            if (w_div_wr || !w_en_nxt || w_tick) begin
                r_count <= 16'd0;
            end else begin
                r_count <= r_count + 16'd1;
            end

            if (w_tick && w_empty) begin
                r_underrun <= 1'b1;
            end else if (w_ctrl_wr && HWDATA[c_ctrl_clr_urun_bit]) begin
                r_underrun <= 1'b0;
            end

            r_dac_valid <= w_pop;
            if (w_pop) begin
                r_dac_data <= w_fifo_dout;
            end
        end
    end

    assign dac_data  = r_dac_data;
    assign dac_valid = r_dac_valid;

    dac_sample_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .LVL_W      (c_lvl_w)
    ) u_fifo (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .push   (w_push),
        .din    (HWDATA[DATA_WIDTH-1:0]),
        .pop    (w_pop),
        .dout   (w_fifo_dout),
        .full   (w_full),
        .empty  (w_empty),
        .level  (w_level)
    );

endmodule

`default_nettype wire

// File: tb/tb_ahblite_dac.sv
// ============================================================================
// Module   : tb_ahblite_dac
// Brief    : Directed self-checking bench for ahblite_dac (default parameters).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ahblite_dac;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic [7:0]  dac_data;
    logic        dac_valid;

    int total = 0;
    int bad   = 0;

    always #5 HCLK = ~HCLK;

    // Single slave on the bus: its ready is the bus ready
    assign HREADY = HREADYOUT;

    ahblite_dac #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (8),
        .DIV_RESET  (99)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HPROT     (HPROT),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRDATA    (HRDATA),
        .HRESP     (HRESP),
        .dac_data  (dac_data),
        .dac_valid (dac_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic addr_phase(input logic [3:0] a, input logic wr);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = {28'h0, a};
        HWRITE = wr;
        step();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
    endtask

    task automatic ahb_write(input logic [3:0] a, input logic [31:0] d);
        int n;
        n = 0;
        addr_phase(a, 1'b1);
        HWDATA = d;
        while (HREADYOUT !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) check("write_timeout", {31'd0, HREADYOUT}, 32'd1);
        step();
    endtask

    task automatic ahb_read(input logic [3:0] a, output logic [31:0] d);
        addr_phase(a, 1'b0);
        d = HRDATA;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        prev_rdy;
        int          n;

        HRESET = 1'b1;
        HSEL   = 1'b0;
        HADDR  = 32'd0;
        HTRANS = 2'b00;
        HSIZE  = 3'b010;
        HPROT  = 4'b0011;
        HWRITE = 1'b0;
        HWDATA = 32'd0;
        repeat (3) @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        // Reset state
        check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("rst_hrdata", HRDATA, 32'd0);
        check("rst_hresp", {31'd0, HRESP}, 32'd0);
        check("rst_dac_data", {24'd0, dac_data}, 32'd0);
        check("rst_dac_valid", {31'd0, dac_valid}, 32'd0);
        ahb_read(4'h8, rd); check("rst_status", rd, 32'h0000_0001);
        ahb_read(4'h4, rd); check("rst_div", rd, 32'd99);
        ahb_read(4'hC, rd); check("rst_ctrl", rd, 32'd0);
        ahb_read(4'h0, rd); check("data_reads_zero", rd, 32'd0);

        // DIV=3: first sample 3 cycles after enable edge, next 4 cycles later
        ahb_write(4'h4, 32'd3);
        ahb_write(4'h0, 32'h11);
        ahb_write(4'h0, 32'h22);
        ahb_read(4'h8, rd); check("status_lvl2", rd, 32'h0000_0200);
        ahb_read(4'h4, rd); check("div_rb3", rd, 32'd3);
        ahb_write(4'hC, 32'd1);
        step(); step();
        check("div3_pre_valid", {31'd0, dac_valid}, 32'd0);
        check("div3_pre_data", {24'd0, dac_data}, 32'd0);
        step();
        check("div3_s1_data", {24'd0, dac_data}, 32'h11);
        check("div3_s1_valid", {31'd0, dac_valid}, 32'd1);
        step();
        check("div3_s1_pulse", {31'd0, dac_valid}, 32'd0);
        step(); step();
        check("div3_s2_pre", {31'd0, dac_valid}, 32'd0);
        step();
        check("div3_s2_data", {24'd0, dac_data}, 32'h22);
        check("div3_s2_valid", {31'd0, dac_valid}, 32'd1);
        ahb_write(4'hC, 32'd0);
        ahb_read(4'h8, rd); check("div3_status_end", rd, 32'h0000_0001);

        // DIV=0 with empty FIFO: underrun; set wins over clear while still enabled
        ahb_write(4'h4, 32'd0);
        ahb_write(4'hC, 32'd1);
        ahb_read(4'h8, rd); check("urun_set", rd, 32'h0000_0005);
        ahb_write(4'hC, 32'd3);
        ahb_read(4'h8, rd); check("urun_set_wins", rd, 32'h0000_0005);
        ahb_read(4'hC, rd); check("ctrl_rb_en", rd, 32'd1);
        ahb_write(4'hC, 32'd2);
        ahb_read(4'h8, rd); check("urun_cleared", rd, 32'h0000_0001);
        ahb_read(4'hC, rd); check("ctrl_clr_reads0", rd, 32'd0);

        // Upper write bits dropped
        ahb_write(4'h4, 32'd2);
        ahb_write(4'h0, 32'hABCD_1234);
        ahb_write(4'hC, 32'd1);
        step(); step();
        check("trunc_data", {24'd0, dac_data}, 32'h34);
        check("trunc_valid", {31'd0, dac_valid}, 32'd1);
        ahb_write(4'hC, 32'd0);
        ahb_read(4'h8, rd); check("trunc_status", rd, 32'h0000_0001);

        // Fill FIFO, 9th write stalls until the first tick pops
        ahb_write(4'h4, 32'd40);
        ahb_write(4'hC, 32'd1);
        for (int i = 0; i < 8; i++) ahb_write(4'h0, 32'h80 + i);
        ahb_read(4'h8, rd); check("full_status", rd, 32'h0000_0802);
        addr_phase(4'h0, 1'b1);
        HWDATA = 32'h99;
        check("stall_start", {31'd0, HREADYOUT}, 32'd0);
        n = 0;
        prev_rdy = HREADYOUT;
        while (dac_valid !== 1'b1 && n < 100) begin
            prev_rdy = HREADYOUT;
            step();
            n++;
        end
        check("stall_cycles", n, 32'd21);
        check("stall_held_at_pop", {31'd0, prev_rdy}, 32'd0);
        check("stall_release", {31'd0, HREADYOUT}, 32'd1);
        check("stall_pop_data", {24'd0, dac_data}, 32'h80);
        step();
        ahb_read(4'h8, rd); check("full_after_push", rd, 32'h0000_0802);

        // Reset while a write is stalled on a full FIFO
        ahb_write(4'hC, 32'd0);
        addr_phase(4'h0, 1'b1);
        HWDATA = 32'hEE;
        check("stall2_start", {31'd0, HREADYOUT}, 32'd0);
        HRESET = 1'b1;
        step();
        check("rst_stall_rdy", {31'd0, HREADYOUT}, 32'd1);
        HRESET = 1'b0;
        check("rst_stall_data", {24'd0, dac_data}, 32'd0);
        check("rst_stall_valid", {31'd0, dac_valid}, 32'd0);
        ahb_read(4'h8, rd); check("rst_stall_status", rd, 32'h0000_0001);
        ahb_read(4'h4, rd); check("rst_stall_div", rd, 32'd99);
        ahb_read(4'hC, rd); check("rst_stall_ctrl", rd, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
